// File: rtl/dmem_access.sv
// Data-memory access unit: converts MEM-stage load/store requests into byte-lane RAM accesses.
// Optional macro DMEM_MISALIGN_EXC_EN: misaligned half/word requests complete early with resp_err set.
module dmem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic              accept_s;
  logic              misalign_s;
  logic              wr_r;
  logic              signed_r;
  logic [1:0]        size_r;
  logic [1:0]        off_r;
  logic [3:0]        lanes_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       din_r;
  logic [31:0]       rdata_r;
  logic              err_r;

  function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] lanes;
    case (size)
      2'b00:   lanes = 4'b0001 << off;
      2'b01:   lanes = off[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      2'b00:   data = {4{wdata[7:0]}};
      2'b01:   data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  // Half loads look only at addr[1] and word loads ignore the offset, so stray low bits are dropped here.
  function automatic logic [31:0] load_extract(input logic [31:0] dout, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] result;
    shifted = dout >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? dout[31:16] : dout[15:0];
    case (size)
      2'b00:   result = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
      2'b01:   result = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      default: result = dout;
    endcase
    return result;
  endfunction

  assign accept_s = req_valid && (state_r == IDLE);

`ifdef DMEM_MISALIGN_EXC_EN
  // Misalignment of the incoming request: half on an odd byte, word on any non-zero offset.
  always_comb begin
    misalign_s = 1'b0;
    case (req_size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = req_addr[0];
      default: misalign_s = (req_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = misalign_s ? DONE : ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE:   state_nx_s = wr_r ? DONE : READ;
      READ:    state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from state; a reset clears state_r at once, which drops ram_we without waiting for an edge.
  always_comb begin
    req_ready  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 4'b0000;
    resp_valid = 1'b0;
    case (state_r)
      IDLE:  req_ready = 1'b1;
      ISSUE: begin
        ram_en = 1'b1;
        ram_we = wr_r ? lanes_r : 4'b0000;
      end
      READ:    ram_en = 1'b0;
      DONE:    resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Request capture at accept and load-result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r     <= 1'b0;
      signed_r <= 1'b0;
      size_r   <= 2'b00;
      off_r    <= 2'b00;
      lanes_r  <= 4'b0000;
      addr_r   <= {ADDR_W{1'b0}};
      din_r    <= 32'h0000_0000;
      err_r    <= 1'b0;
      rdata_r  <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        wr_r     <= req_wr;
        signed_r <= req_signed;
        size_r   <= req_size;
        off_r    <= req_addr[1:0];
        lanes_r  <= byte_lanes(req_size, req_addr[1:0]);
        addr_r   <= {2'b00, req_addr[ADDR_W-1:2]};
        din_r    <= store_data(req_size, req_wdata);
        err_r    <= misalign_s;
      end
      if (accept_s && misalign_s) begin
        rdata_r <= 32'h0000_0000;
      end else if (state_r == READ) begin
        rdata_r <= load_extract(ram_dout, size_r, signed_r, off_r);
      end
    end
  end

  assign ram_addr   = addr_r;
  assign ram_din    = din_r;
  assign resp_rdata = rdata_r;
  assign resp_err   = err_r;

endmodule
